mmio_timer: RTL and testbench

//  Memory-mapped timer/compare peripheral on the MMIO side of memmap, decoded next to the UART and hex-display slots.

---
 rtl/mmio_timer_pkg.sv | 18 +
 rtl/mmio_prescaler.sv | 21 ++
 rtl/mmio_timer.sv | 87 ++++++++
 tb/tb_mmio_timer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mmio_timer_pkg.sv
// Shared definitions for the MMIO timer/compare peripheral: bus width, window base,
// register offsets and CTRL bit positions.
package mmio_timer_pkg;
  localparam int DATA_WIDTH = 32;
  localparam logic [15:0] TIMER_BASE = 16'hFFE0;

  typedef enum logic [2:0] {
    REG_CTRL     = 3'd0,
    REG_PRESCALE = 3'd1,
    REG_COUNT    = 3'd2,
    REG_COMPARE  = 3'd3,
    REG_STATUS   = 3'd4
  } timer_reg_e;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_RELOAD = 1;
  localparam int CTRL_IRQ_EN = 2;
endpackage

// File: rtl/mmio_prescaler.sv
// Clock prescaler: while enabled, counts 0..i_div and emits a one-cycle tick
// when the count equals i_div, then restarts at 0.
module mmio_prescaler #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_div,
  output logic         o_tick
);
  logic [W-1:0] pre_cnt;

  assign o_tick = i_en && (pre_cnt == i_div);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) pre_cnt <= '0;
    else if (i_en)      pre_cnt <= o_tick ? '0 : pre_cnt + 1'b1;
  end
endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped timer/compare slot: prescaled COUNT, sticky match flag with W1C,
// optional auto-reload, zero-latency combinational MMIO handshake.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter int          PRESCALE_WIDTH = 16,
  parameter logic [31:0] RESET_COMPARE  = 32'hFFFF_FFFF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_sel,
  input  logic [2:0]            i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  output logic                  o_irq
);
  logic [2:0]                ctrl;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic [31:0]               count;
  logic [31:0]               compare;
  logic                      match;
  logic                      wr, rd, tick, hit, pre_clr;
  timer_reg_e                reg_sel;

  assign reg_sel = timer_reg_e'(i_addr);
  assign wr      = i_sel & i_wr_valid;
  assign rd      = i_sel & i_rd_ready;
  assign hit     = (count == compare);
  assign pre_clr = wr && (reg_sel == REG_CTRL || reg_sel == REG_PRESCALE);
  assign o_irq   = match & ctrl[CTRL_IRQ_EN];

  mmio_prescaler #(.W(PRESCALE_WIDTH)) u_pre (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (ctrl[CTRL_EN]),
    .i_clr  (pre_clr),
    .i_div  (prescale),
    .o_tick (tick)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ctrl     <= '0;
      prescale <= '0;
      count    <= '0;
      compare  <= RESET_COMPARE;
      match    <= 1'b0;
    end else begin
      if (tick) begin
        if (hit) match <= 1'b1;
        count <= (hit && ctrl[CTRL_RELOAD]) ? 32'd0 : count + 32'd1;
      end
      // Bus writes come after the tick update so a COUNT write overrides it;
      // the W1C is suppressed when a match is being set on the same edge.
      if (wr) begin
        case (reg_sel)
          REG_CTRL:     ctrl     <= i_data[2:0];
          REG_PRESCALE: prescale <= i_data[PRESCALE_WIDTH-1:0];
          REG_COUNT:    count    <= i_data[31:0];
          REG_COMPARE:  compare  <= i_data[31:0];
          REG_STATUS:   if (i_data[0] && !(tick && hit)) match <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    o_wr_ready = wr;
    o_rd_valid = rd;
    o_data     = '0;
    if (rd) begin
      case (reg_sel)
        REG_CTRL:     o_data = DATA_WIDTH'(ctrl);
        REG_PRESCALE: o_data = DATA_WIDTH'(prescale);
        REG_COUNT:    o_data = DATA_WIDTH'(count);
        REG_COMPARE:  o_data = DATA_WIDTH'(compare);
        REG_STATUS:   o_data = DATA_WIDTH'(match);
        default:      o_data = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: reads push expected {data,irq} into a queue and a
// negedge monitor pops and compares whenever the DUT presents read data.
module tb_mmio_timer;
  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] rdata;
  logic        rd_valid;
  logic        rd_ready;
  logic        irq;

  typedef struct {
    logic [31:0] data;
    logic        irq;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  logic expect_idle = 1'b0;
  logic done        = 1'b0;

  mmio_timer dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_sel      (sel),
    .i_addr     (addr),
    .i_data     (wdata),
    .i_wr_valid (wr_valid),
    .o_wr_ready (wr_ready),
    .o_data     (rdata),
    .o_rd_valid (rd_valid),
    .i_rd_ready (rd_ready),
    .o_irq      (irq)
  );

  always #5 clk = ~clk;

  // Monitor: the only process that touches the comparison counters.
  always @(negedge clk) begin
    if (rd_valid) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_read: got data=%h irq=%b with nothing expected", rdata, irq);
      end else begin
        e = q.pop_front();
        if (rdata !== e.data || irq !== e.irq) begin
          bad++;
          $display("FAIL %s: got data=%h irq=%b want data=%h irq=%b",
                   e.name, rdata, irq, e.data, e.irq);
        end
      end
    end else if (expect_idle) begin
      total++;
      if (rd_valid !== 1'b0 || wr_ready !== 1'b0 || rdata !== 32'd0) begin
        bad++;
        $display("FAIL deselected_idle: got rd_valid=%b wr_ready=%b data=%h want 0 0 0",
                 rd_valid, wr_ready, rdata);
      end
    end
    if (done) begin
      total++;
      if (q.size() != 0) begin
        bad++;
        $display("FAIL reads_outstanding: got %0d unanswered want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  // Each task is entered 1 time unit after a posedge and returns 1 unit after the next.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    sel = 1'b1; wr_valid = 1'b1; addr = a; wdata = d;
    step();
    sel = 1'b0; wr_valid = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] d, input logic i, input string n);
    exp_t x;
    x.data = d; x.irq = i; x.name = n;
    q.push_back(x);
    sel = 1'b1; rd_ready = 1'b1; addr = a;
    step();
    sel = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    rd(3'd0, 32'd0,          1'b0, {tag, "_ctrl"});
    rd(3'd1, 32'd0,          1'b0, {tag, "_prescale"});
    rd(3'd2, 32'd0,          1'b0, {tag, "_count"});
    rd(3'd3, 32'hFFFF_FFFF,  1'b0, {tag, "_compare"});
    rd(3'd4, 32'd0,          1'b0, {tag, "_status"});
    rd(3'd6, 32'd0,          1'b0, {tag, "_off6"});
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; addr = '0; wdata = '0; wr_valid = 1'b0; rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and unused offsets.
    check_reset_values("rst");
    wr(3'd5, 32'h1234_5678);
    rd(3'd5, 32'd0,         1'b0, "off5_ignored");
    rd(3'd3, 32'hFFFF_FFFF, 1'b0, "off5_no_side_effect");

    // Prescale 3, compare 5, auto-reload: match on the 24th cycle, then every 24.
    do_reset();
    wr(3'd1, 32'd3);
    wr(3'd3, 32'd5);
    wr(3'd0, 32'b011);
    idle(22);
    rd(3'd4, 32'd0, 1'b0, "reload_pre_23");
    rd(3'd4, 32'd0, 1'b0, "reload_pre_24");
    rd(3'd4, 32'd1, 1'b0, "reload_match_24");
    rd(3'd2, 32'd0, 1'b0, "reload_count_zero");
    wr(3'd4, 32'd1);
    idle(20);
    rd(3'd4, 32'd0, 1'b0, "reload_pre_48");
    rd(3'd4, 32'd1, 1'b0, "reload_match_48");

    // Wrap past FFFF_FFFF with no flag until COUNT reaches COMPARE.
    do_reset();
    wr(3'd3, 32'd10);
    wr(3'd2, 32'hFFFF_FFFE);
    wr(3'd0, 32'b001);
    rd(3'd2, 32'hFFFF_FFFE, 1'b0, "wrap_start");
    rd(3'd2, 32'hFFFF_FFFF, 1'b0, "wrap_max");
    rd(3'd2, 32'd0,         1'b0, "wrap_zero");
    rd(3'd4, 32'd0,         1'b0, "wrap_no_flag");
    idle(8);
    rd(3'd4, 32'd0,  1'b0, "wrap_at10_noflag");
    rd(3'd4, 32'd1,  1'b0, "wrap_match10");
    rd(3'd2, 32'd12, 1'b0, "wrap_no_reload");

    // irq follows match & irq_en; W1C drops it.
    wr(3'd0, 32'b101);
    rd(3'd4, 32'd1, 1'b1, "irq_high");
    wr(3'd4, 32'd1);
    rd(3'd4, 32'd0, 1'b0, "irq_cleared");

    // W1C on the same edge as a match: match wins. Then COUNT write beats a tick.
    do_reset();
    wr(3'd3, 32'd5);
    wr(3'd2, 32'd3);
    wr(3'd0, 32'b101);
    idle(2);
    wr(3'd4, 32'd1);
    rd(3'd4, 32'd1, 1'b1, "w1c_vs_match");
    wr(3'd2, 32'd100);
    rd(3'd2, 32'd100, 1'b1, "count_write_wins");

    // PRESCALE write mid-count restarts the prescaler.
    do_reset();
    wr(3'd1, 32'd3);
    wr(3'd0, 32'b001);
    idle(2);
    wr(3'd1, 32'd3);
    rd(3'd2, 32'd0, 1'b0, "prerestart_0");
    rd(3'd2, 32'd0, 1'b0, "prerestart_1");
    rd(3'd2, 32'd0, 1'b0, "prerestart_2");
    rd(3'd2, 32'd0, 1'b0, "prerestart_3");
    rd(3'd2, 32'd1, 1'b0, "prerestart_tick");

    // Reset mid-count returns everything to reset values.
    do_reset();
    wr(3'd2, 32'd7);
    wr(3'd1, 32'd5);
    wr(3'd3, 32'd9);
    wr(3'd0, 32'b111);
    idle(1);
    do_reset();
    check_reset_values("midrst");

    // Deselected: no valid, no ready, zero data.
    expect_idle = 1'b1; sel = 1'b0; rd_ready = 1'b1; wr_valid = 1'b1; addr = 3'd3;
    step();
    expect_idle = 1'b0; rd_ready = 1'b0; wr_valid = 1'b0;
    rd(3'd3, 32'hFFFF_FFFF, 1'b0, "deselected_write_ignored");

    idle(1);
    done = 1'b1;
    idle(2);
    $display("FAIL monitor_did_not_finish: got running want finished");
    $fatal(1, "monitor did not finish");
  end
endmodule
